// File: rtl/bram_tx_sequencer_pkg.sv
// Shared definitions for the BRAM-to-UART transmit sequencer:
// FSM state encoding and front-panel LED patterns.
package bram_tx_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        REQ     = 3'd2,
        TX_WAIT = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [7:0] LED_IDLE    = 8'b1100_0000;
    localparam logic [7:0] LED_RD_WAIT = 8'b0011_0000;
    localparam logic [7:0] LED_REQ     = 8'b0000_1100;
    localparam logic [7:0] LED_TX_WAIT = 8'b0000_0011;
    localparam logic [7:0] LED_DONE    = 8'b1111_1111;

    // A sticky error shows up as led[0] while parked in IDLE.
    function automatic logic [7:0] led_pattern(input state_t s, input logic err);
        case (s)
            IDLE:    return err ? (LED_IDLE | 8'h01) : LED_IDLE;
            RD_WAIT: return LED_RD_WAIT;
            REQ:     return LED_REQ;
            TX_WAIT: return LED_TX_WAIT;
            DONE:    return LED_DONE;
            default: return LED_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/bram_tx_sequencer_if.sv
// BRAM read-port and UART transmit handshake bundle; the sequencer is the master.
interface bram_tx_sequencer_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_dout;
    logic [DATA_W-1:0] tx_data;
    logic              tx_req;
    logic              tx_busy;

    modport master (
        output bram_addr, tx_data, tx_req,
        input  bram_dout, tx_busy
    );

    modport slave (
        input  bram_addr, tx_data, tx_req,
        output bram_dout, tx_busy
    );
endinterface

// File: rtl/bram_tx_sequencer_rise_detect.sv
// Rising-edge detector for the start level input.
module rise_detect (
    input  logic w_clk,
    input  logic w_resetn,
    input  logic d,
    output logic rise
);
    logic d_q;
    logic armed;

    // Only arm after the input has been seen low, so a level held through reset is not an edge.
    always_ff @(posedge w_clk or negedge w_resetn) begin
        if (!w_resetn) begin
            d_q   <= 1'b0;
            armed <= 1'b0;
        end else begin
            d_q <= d;
            if (!d) armed <= 1'b1;
        end
    end

    assign rise = armed & d & ~d_q;
endmodule

// File: rtl/bram_tx_sequencer.sv
// Walks BRAM addresses 0..DEPTH-1 once per start edge and hands each byte to the UART
// with a req/busy handshake, stopping after the last address.
module bram_tx_sequencer
    import bram_tx_pkg::*;
#(
    parameter int DEPTH       = 2048,
    parameter int ADDR_W      = 11,
    parameter int DATA_W      = 8,
    parameter int RD_LAT      = 2,
    parameter int REQ_TIMEOUT = 1024
) (
    input  logic                 CLK_50M,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    bram_tx_sequencer_if.master  bus,
    output logic                 active,
    output logic                 done,
    output logic                 err,
    output logic [ADDR_W:0]      byte_cnt,
    output logic [7:0]           led
);
    localparam int                TMO_W     = $clog2(REQ_TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state, state_d;
    logic [1:0]        lat_cnt, lat_cnt_d;
    logic [TMO_W-1:0]  tmo_cnt, tmo_cnt_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] data_d;
    logic              req_d, err_d;
    logic [ADDR_W:0]   byte_cnt_d;
    logic              start_rise;

    rise_detect u_start_rise (
        .w_clk    (CLK_50M),
        .w_resetn (rst_n),
        .d        (start),
        .rise     (start_rise)
    );

    always_comb begin
        state_d    = state;
        lat_cnt_d  = lat_cnt;
        tmo_cnt_d  = tmo_cnt;
        addr_d     = bus.bram_addr;
        data_d     = bus.tx_data;
        req_d      = bus.tx_req;
        err_d      = err;
        byte_cnt_d = byte_cnt;
        case (state)
            IDLE: begin
                if (start_rise && !abort) begin
                    state_d    = RD_WAIT;
                    addr_d     = '0;
                    byte_cnt_d = '0;
                    err_d      = 1'b0;
                    lat_cnt_d  = 2'(RD_LAT);
                end
            end
            RD_WAIT: begin
                lat_cnt_d = lat_cnt - 2'd1;
                if (lat_cnt == 2'd1) begin
                    data_d    = bus.bram_dout;
                    req_d     = 1'b1;
                    tmo_cnt_d = '0;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (bus.tx_busy) begin
                    req_d   = 1'b0;
                    state_d = TX_WAIT;
                end else if (tmo_cnt == TMO_W'(REQ_TIMEOUT - 1)) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt + 1'b1;
                end
            end
            TX_WAIT: begin
                if (!bus.tx_busy) begin
                    byte_cnt_d = byte_cnt + 1'b1;
                    // Compare before incrementing so the address stops at LAST_ADDR.
                    if (bus.bram_addr == LAST_ADDR) begin
                        state_d = DONE;
                    end else begin
                        addr_d    = bus.bram_addr + 1'b1;
                        lat_cnt_d = 2'(RD_LAT);
                        state_d   = RD_WAIT;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort && state != IDLE) begin
            state_d    = IDLE;
            req_d      = 1'b0;
            err_d      = err;
            addr_d     = bus.bram_addr;
            byte_cnt_d = byte_cnt;
        end
    end

    always_ff @(posedge CLK_50M or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            lat_cnt       <= '0;
            tmo_cnt       <= '0;
            bus.bram_addr <= '0;
            bus.tx_data   <= '0;
            bus.tx_req    <= 1'b0;
            err           <= 1'b0;
            byte_cnt      <= '0;
            active        <= 1'b0;
            done          <= 1'b0;
            led           <= LED_IDLE;
        end else begin
            state         <= state_d;
            lat_cnt       <= lat_cnt_d;
            tmo_cnt       <= tmo_cnt_d;
            bus.bram_addr <= addr_d;
            bus.tx_data   <= data_d;
            bus.tx_req    <= req_d;
            err           <= err_d;
            byte_cnt      <= byte_cnt_d;
            active        <= (state_d == RD_WAIT) || (state_d == REQ) || (state_d == TX_WAIT);
            done          <= (state_d == DONE);
            led           <= led_pattern(state_d, err_d);
        end
    end
endmodule
